// File: rtl/eth_phy_10g_rx_gearbox_slip.sv
// Fabric bitslip for a raw 66-bit deserializer stream: each rising edge of serdes_rx_bitslip advances the block window by one bit.
// Define RX_GEARBOX_SLIP_STATUS_EN to add the slip_offset and slip_wrap_count status outputs.
module eth_phy_10g_rx_gearbox_slip #(
  parameter int DATA_WIDTH      = 64,
  parameter int HDR_WIDTH       = 2,
  parameter int BIT_REVERSE     = 0,
  parameter int OUTPUT_PIPELINE = 0
) (
  input  logic                            rx_clk,
  input  logic                            rx_rst,
  input  logic [DATA_WIDTH+HDR_WIDTH-1:0] raw_data,
  input  logic                            serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0]           serdes_rx_data,
  output logic [HDR_WIDTH-1:0]            serdes_rx_hdr,
  output logic                            serdes_rx_valid
`ifdef RX_GEARBOX_SLIP_STATUS_EN
  ,
  output logic [6:0]                      slip_offset,
  output logic [15:0]                     slip_wrap_count
`endif
);

  localparam int W    = DATA_WIDTH + HDR_WIDTH;
  localparam int PIPE = OUTPUT_PIPELINE;

  logic [W-1:0]   raw_word;
  logic [W-1:0]   prev_word;
  logic [6:0]     offset;
  logic           bitslip_last;
  logic           primed;
  logic           skip;
  logic           slip;
  logic [2*W-1:0] combined;
  logic [7:0]     win_idx;
  logic [W-1:0]   window;

  logic [DATA_WIDTH-1:0] pipe_data  [0:PIPE];
  logic [HDR_WIDTH-1:0]  pipe_hdr   [0:PIPE];
  logic                  pipe_valid [0:PIPE];

`ifdef RX_GEARBOX_SLIP_STATUS_EN
  logic [15:0] wrap_count;
`endif

  always_comb begin
    raw_word = raw_data;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < W; i++) raw_word[i] = raw_data[W-1-i];
    end
  end

  // Older word sits in the low half, so a larger offset selects later bits of the stream.
  assign combined = {raw_word, prev_word};
  assign win_idx  = {1'b0, offset};
  assign window   = combined[win_idx +: W];
  assign slip     = serdes_rx_bitslip & ~bitslip_last;

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      prev_word    <= '0;
      offset       <= '0;
      // Sampling the request during reset stops a level held across release from looking like a new edge.
      bitslip_last <= serdes_rx_bitslip;
      primed       <= 1'b0;
      skip         <= 1'b0;
      // NOTE: every pipeline stage is cleared as well, so a stale valid can never drain out after reset.
      for (int i = 0; i <= PIPE; i++) begin
        pipe_data[i]  <= '0;
        pipe_hdr[i]   <= '0;
        pipe_valid[i] <= 1'b0;
      end
`ifdef RX_GEARBOX_SLIP_STATUS_EN
      wrap_count   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the pre-edge value of the others.
      prev_word    <= raw_word;
      bitslip_last <= serdes_rx_bitslip;
      primed       <= 1'b1;
      skip         <= 1'b0;

      if (slip) begin
        if (offset == 7'(W - 1)) begin
          // Offset 0 on the next cycle would repeat the word just consumed; the skip drops it.
          offset <= '0;
          skip   <= 1'b1;
`ifdef RX_GEARBOX_SLIP_STATUS_EN
          if (wrap_count != 16'hFFFF) wrap_count <= wrap_count + 16'd1;
`endif
        end else begin
          offset <= offset + 7'd1;
        end
      end

      if (!skip) begin
        pipe_data[0] <= window[W-1:HDR_WIDTH];
        pipe_hdr[0]  <= window[HDR_WIDTH-1:0];
      end
      pipe_valid[0] <= primed & ~skip;

      for (int i = 1; i <= PIPE; i++) begin
        pipe_data[i]  <= pipe_data[i-1];
        pipe_hdr[i]   <= pipe_hdr[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  assign serdes_rx_data  = pipe_data[PIPE];
  assign serdes_rx_hdr   = pipe_hdr[PIPE];
  assign serdes_rx_valid = pipe_valid[PIPE];

`ifdef RX_GEARBOX_SLIP_STATUS_EN
  assign slip_offset     = offset;
  assign slip_wrap_count = wrap_count;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox_slip.sv
// Self-checking bench for eth_phy_10g_rx_gearbox_slip: three instances (plain, OUTPUT_PIPELINE=2, BIT_REVERSE=1) share one stimulus.
// Status outputs are checked when RX_GEARBOX_SLIP_STATUS_EN is defined.
module tb_eth_phy_10g_rx_gearbox_slip;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        valid;
  } out_t;

  typedef struct {
    logic [65:0] raw;
    logic        bs;
    out_t        exp;
  } vec_t;

  logic        rx_clk            = 1'b0;
  logic        rx_rst            = 1'b1;
  logic [65:0] raw_data          = '0;
  logic [65:0] raw_rev;
  logic        serdes_rx_bitslip = 1'b0;

  logic [63:0] d0, d2, dr;
  logic [1:0]  h0, h2, hr;
  logic        v0, v2, vr;
`ifdef RX_GEARBOX_SLIP_STATUS_EN
  logic [6:0]  so0, so2, sor;
  logic [15:0] sw0, sw2, swr;
`endif

  function automatic logic [65:0] rev66(input logic [65:0] x);
    logic [65:0] r;
    for (int i = 0; i < 66; i++) r[i] = x[65-i];
    return r;
  endfunction

  assign raw_rev = rev66(raw_data);

  eth_phy_10g_rx_gearbox_slip #(.OUTPUT_PIPELINE(0)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .raw_data(raw_data), .serdes_rx_bitslip(serdes_rx_bitslip),
    .serdes_rx_data(d0), .serdes_rx_hdr(h0), .serdes_rx_valid(v0)
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    , .slip_offset(so0), .slip_wrap_count(sw0)
`endif
  );

  eth_phy_10g_rx_gearbox_slip #(.OUTPUT_PIPELINE(2)) dut_p2 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .raw_data(raw_data), .serdes_rx_bitslip(serdes_rx_bitslip),
    .serdes_rx_data(d2), .serdes_rx_hdr(h2), .serdes_rx_valid(v2)
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    , .slip_offset(so2), .slip_wrap_count(sw2)
`endif
  );

  eth_phy_10g_rx_gearbox_slip #(.BIT_REVERSE(1)) dut_rev (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .raw_data(raw_rev), .serdes_rx_bitslip(serdes_rx_bitslip),
    .serdes_rx_data(dr), .serdes_rx_hdr(hr), .serdes_rx_valid(vr)
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    , .slip_offset(sor), .slip_wrap_count(swr)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wj       = 0;

  // Reference model: a bit-level view of the received stream since reset.
  logic [65:0] hist[$];
  int          m_off;
  logic        m_last, m_primed, m_skip;
  out_t        m_out;
  int          m_wraps;
  out_t        q0[$];
  out_t        q2[$];

  task automatic check_out(input string nm, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got data=%h hdr=%b valid=%b, expected data=%h hdr=%b valid=%b",
               nm, cyc, act.data, act.hdr, act.valid, exp.data, exp.hdr, exp.valid);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic sbit(input int p);
    if (p < 0) return 1'b0;
    return hist[p/66][p%66];
  endfunction

  function automatic logic [65:0] aw(input int n);
    return {64'd1 + 64'(n), 2'b01};
  endfunction

  function automatic logic [63:0] pr(input int n);
    return 64'hC0DE_5A5A_0000_0000 + 64'(n);
  endfunction

  // Raw words of a block stream preceded by five junk bits.
  function automatic logic [65:0] rw(input int j);
    logic [4:0]  jk;
    logic [65:0] r, blk;
    int p, q;
    jk = 5'b01101;
    for (int b = 0; b < 66; b++) begin
      p = 66 * j + b;
      if (p < 5) r[b] = jk[p];
      else begin
        q      = p - 5;
        blk    = {pr(q / 66), 2'b01};
        r[b]   = blk[q % 66];
      end
    end
    return r;
  endfunction

  function automatic logic [65:0] rnd66();
    logic [95:0] x;
    x = {$urandom, $urandom, $urandom};
    return x[65:0];
  endfunction

  task automatic cycle(input logic [65:0] raw, input logic bs, input bit use_exp, input out_t exp_in);
    out_t        e, x;
    logic [65:0] w;
    int          start;
    logic        ns;
    raw_data          = raw;
    serdes_rx_bitslip = bs;
    if (rx_rst) begin
      hist.delete();
      m_off = 0; m_last = bs; m_primed = 1'b0; m_skip = 1'b0; m_wraps = 0;
      m_out = '0; e = '0;
      q0.delete(); q2.delete();
      q2.push_back('0); q2.push_back('0);
    end else begin
      hist.push_back(raw);
      start = (hist.size() - 2) * 66 + m_off;
      if (m_skip) e = {m_out.data, m_out.hdr, 1'b0};
      else begin
        for (int b = 0; b < 66; b++) w[b] = sbit(start + b);
        e = {w[65:2], w[1:0], m_primed};
      end
      m_out = e;
      ns = 1'b0;
      if (bs && !m_last) begin
        if (m_off == 65) begin
          m_off = 0; ns = 1'b1;
          if (m_wraps < 65535) m_wraps++;
        end else m_off++;
      end
      m_last = bs; m_primed = 1'b1; m_skip = ns;
      if (use_exp) e = exp_in;
    end
    q0.push_back(e);
    q2.push_back(e);
    @(posedge rx_clk);
    #1;
    cyc++;
    x = q0.pop_front();
    check_out("p0 out", {d0, h0, v0}, x);
    check_out("rev out", {dr, hr, vr}, x);
    x = q2.pop_front();
    check_out("p2 out", {d2, h2, v2}, x);
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    check_val("p0 offset", int'(so0), m_off);
    check_val("p2 offset", int'(so2), m_off);
    check_val("rev offset", int'(sor), m_off);
    check_val("p0 wraps", int'(sw0), m_wraps);
    check_val("p2 wraps", int'(sw2), m_wraps);
`endif
  endtask

  task automatic cycle_aw(input logic bs);
    cycle(aw(wj), bs, 1'b0, '0);
    wj++;
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    cycle(rnd66(), 1'b0, 1'b0, '0);
    rx_rst = 1'b0;
    wj = 0;
  endtask

  task automatic check_aligned(input string nm);
    check_out(nm, {d0, h0, v0}, {64'(wj - 1), 2'b01, 1'b1});
  endtask

  task automatic check_shift1(input string nm);
    logic [65:0] a, b, w;
    a = aw(wj - 1);
    b = aw(wj - 2);
    w = {a[0], b[65:1]};
    check_out(nm, {d0, h0, v0}, {w[65:2], w[1:0], 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int   gaps0, gaps2, gap_cyc0, gap_cyc2;

    // Reset, then an aligned stream driven from a table of expected outputs.
    rx_rst = 1'b1;
    repeat (2) cycle(rnd66(), 1'b0, 1'b0, '0);
    check_out("reset out", {d0, h0, v0}, '0);
    rx_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vt[i].raw = aw(i);
      vt[i].bs  = 1'b0;
      vt[i].exp = (i == 0) ? out_t'('0) : out_t'({64'(i), 2'b01, 1'b1});
    end
    for (int i = 0; i < 4; i++) cycle(vt[i].raw, vt[i].bs, 1'b1, vt[i].exp);

    // Stream rotated by five bits, recovered with five single-cycle pulses.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cycle(rw(wj), 1'b1, 1'b0, '0); wj++;
      repeat (8) begin cycle(rw(wj), 1'b0, 1'b0, '0); wj++; end
    end
    cycle(rw(wj), 1'b1, 1'b0, '0); wj++;
    repeat (10) begin
      cycle(rw(wj), 1'b0, 1'b0, '0);
      check_out("rotated aligned", {d0, h0, v0}, {pr(wj - 1), 2'b01, 1'b1});
      wj++;
    end

    // Request held high for ten cycles gives a single one-bit slip.
    do_reset();
    repeat (3) cycle_aw(1'b0);
    repeat (10) cycle_aw(1'b1);
    repeat (4) begin cycle_aw(1'b0); check_shift1("held shift"); end
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    check_val("held offset", int'(so0), 1);
`endif

    // Slip in the priming cycle is accepted.
    do_reset();
    cycle_aw(1'b1);
    repeat (3) begin cycle_aw(1'b0); check_shift1("prime slip"); end

    // 66 pulses: full wrap, one dropped window, pipeline gap two cycles later.
    do_reset();
    repeat (4) cycle_aw(1'b0);
    gaps0 = 0; gaps2 = 0; gap_cyc0 = 0; gap_cyc2 = 0;
    for (int p = 0; p < 66 * 2 + 4; p++) begin
      cycle_aw((p < 132) ? ((p % 2) == 0) : 1'b0);
      if (!v0) begin gaps0++; gap_cyc0 = cyc; end
      if (!v2) begin gaps2++; gap_cyc2 = cyc; end
    end
    check_val("wrap gaps p0", gaps0, 1);
    check_val("wrap gaps p2", gaps2, 1);
    check_val("wrap gap delay p2", gap_cyc2 - gap_cyc0, 2);
    check_aligned("post-wrap aligned");
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    check_val("wrap offset", int'(so0), 0);
    check_val("wrap count", int'(sw0), 1);
`endif

    // Reset at offset 30 with the request high; no slip until it toggles.
    do_reset();
    cycle_aw(1'b0);
    repeat (30) begin cycle_aw(1'b1); cycle_aw(1'b0); end
    rx_rst = 1'b1;
    cycle(aw(wj), 1'b1, 1'b0, '0);
    check_out("mid reset out", {d0, h0, v0}, '0);
`ifdef RX_GEARBOX_SLIP_STATUS_EN
    check_val("mid reset offset", int'(so0), 0);
`endif
    rx_rst = 1'b0;
    wj = 0;
    repeat (5) begin
      cycle_aw(1'b1);
      if (wj >= 2) check_aligned("no slip after reset");
    end
    cycle_aw(1'b0);
    check_aligned("no slip after fall");
    cycle_aw(1'b1);
    repeat (3) begin cycle_aw(1'b0); check_shift1("slip after toggle"); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
